// File: rtl/snake_pkg.sv
// Shared types and helpers for the multi-snake mover: directions, map tiles,
// direction decoding and single-step coordinate arithmetic.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [3:0] {
        TILE_EMPTY  = 4'd0,
        TILE_SNAKE1 = 4'd1,
        TILE_SNAKE2 = 4'd2,
        TILE_SNAKE3 = 4'd3,
        TILE_SNAKE4 = 4'd4,
        TILE_SNAKE5 = 4'd5,
        TILE_SNAKE6 = 4'd6,
        TILE_SNAKE7 = 4'd7,
        TILE_SNAKE8 = 4'd8,
        TILE_FOOD   = 4'd9,
        TILE_WALL   = 4'd10
    } tile_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } coord_t;

    function automatic tile_t snake_tile(input int idx);
        return tile_t'(4'(idx + 1));
    endfunction

    function automatic dir_t mirror_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Unused encodings (5..7) behave as NONE so a glitchy source cannot move a snake.
    function automatic dir_t decode_dir(input logic [2:0] raw, input logic mirror);
        dir_t d;
        case (raw)
            3'd1:    d = DIR_UP;
            3'd2:    d = DIR_DOWN;
            3'd3:    d = DIR_LEFT;
            3'd4:    d = DIR_RIGHT;
            default: d = DIR_NONE;
        endcase
        return mirror ? mirror_dir(d) : d;
    endfunction

    // Result is 16 bits wide; callers keep only their coordinate width.
    function automatic coord_t step_coord(input logic [15:0] x, input logic [15:0] y,
                                          input dir_t d, input logic wrap,
                                          input int w, input int h);
        coord_t c;
        c.x = x;
        c.y = y;
        case (d)
            DIR_UP:    c.y = (wrap && y == 16'd0) ? 16'(h - 1) : y - 16'd1;
            DIR_DOWN:  c.y = (wrap && y == 16'(h - 1)) ? 16'd0 : y + 16'd1;
            DIR_LEFT:  c.x = (wrap && x == 16'd0) ? 16'(w - 1) : x - 16'd1;
            DIR_RIGHT: c.x = (wrap && x == 16'(w - 1)) ? 16'd0 : x + 16'd1;
            default:   ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/snake_dir_ring.sv
// Circular FIFO of body directions for one snake; the entry at rd_ptr is the
// direction the tail moves next.
module snake_dir_ring
    import snake_pkg::*;
#(
    parameter int MAX_LEN      = 64,
    parameter int START_LENGTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  dir_t push_dir,
    input  logic pop,
    output dir_t peek
);

    localparam int DEPTH = MAX_LEN - 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dir_t          mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // The reset preload makes the starting body a straight vertical line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= DIR_UP;
            rd_ptr <= '0;
            wr_ptr <= PW'((START_LENGTH - 1) % DEPTH);
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dir;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    assign peek = mem[rd_ptr];

endmodule

// File: rtl/snake_multi_mover.sv
// Moves NUM_SNAKES snakes on per-snake step pulses, served round-robin, and
// emits head/tail tile updates through a ready-handshaked map write port.
module snake_multi_mover
    import snake_pkg::*;
#(
    parameter int       NUM_SNAKES    = 2,
    parameter int       MAP_WIDTH     = 64,
    parameter int       MAP_HEIGHT    = 48,
    parameter int       MAX_LEN       = 64,
    parameter int       START_LENGTH  = 4,
    parameter int       START_X       = 8,
    parameter int       START_SPACING = 16,
    parameter int       START_Y       = 10,
    parameter logic [7:0] MIRROR      = 8'b10,
    parameter bit       WRAP          = 1'b1,
    localparam int      XW            = $clog2(MAP_WIDTH),
    localparam int      YW            = $clog2(MAP_HEIGHT),
    localparam int      LW            = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SNAKES-1:0]    step,
    input  logic [NUM_SNAKES*3-1:0]  dir,
    input  logic [NUM_SNAKES-1:0]    grow,
    output logic                     tile_we,
    output logic [XW-1:0]            tile_x,
    output logic [YW-1:0]            tile_y,
    output tile_t                    tile_data,
    input  logic                     tile_ready,
    output logic [NUM_SNAKES*XW-1:0] head_x,
    output logic [NUM_SNAKES*YW-1:0] head_y,
    output logic [NUM_SNAKES*XW-1:0] tail_x,
    output logic [NUM_SNAKES*YW-1:0] tail_y,
    output logic [NUM_SNAKES*LW-1:0] length,
    output logic                     busy,
    output logic [NUM_SNAKES-1:0]    missed_step
);

    localparam int SW = (NUM_SNAKES > 1) ? $clog2(NUM_SNAKES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WR_HEAD, S_WR_TAIL} state_t;

    state_t                state;
    logic [SW-1:0]         sel;
    logic [SW-1:0]         rr_ptr;
    logic [SW-1:0]         pick;
    logic                  pick_vld;
    logic [SW-1:0]         next_rr;
    logic [NUM_SNAKES-1:0] pending;
    logic [NUM_SNAKES-1:0] clr_mask;
    logic [1:0]            grow_cnt [NUM_SNAKES];
    logic [XW-1:0]         hx [NUM_SNAKES];
    logic [YW-1:0]         hy [NUM_SNAKES];
    logic [XW-1:0]         tx [NUM_SNAKES];
    logic [YW-1:0]         ty [NUM_SNAKES];
    logic [LW-1:0]         len [NUM_SNAKES];
    logic [XW-1:0]         old_tx;
    logic [YW-1:0]         old_ty;
    logic                  tail_moved;
    dir_t                  peek [NUM_SNAKES];
    logic [NUM_SNAKES-1:0] push;
    logic [NUM_SNAKES-1:0] pop;
    dir_t                  d;
    coord_t                nh;
    coord_t                nt;
    logic                  grow_dec;
    logic                  grow_ok;
    logic                  unused_coord_hi;

    // Round-robin pick: first pending snake at or above rr_ptr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_SNAKES; k++) begin
            if (!pick_vld && pending[(int'(rr_ptr) + k) % NUM_SNAKES]) begin
                pick     = SW'((int'(rr_ptr) + k) % NUM_SNAKES);
                pick_vld = 1'b1;
            end
        end
        clr_mask = '0;
        if (state == S_IDLE && pick_vld) clr_mask[pick] = 1'b1;
        next_rr = (int'(sel) == NUM_SNAKES - 1) ? '0 : sel + SW'(1);
    end

    always_comb begin
        d        = decode_dir(dir[int'(sel)*3 +: 3], MIRROR[sel]);
        nh       = step_coord(16'(hx[sel]), 16'(hy[sel]), d, WRAP, MAP_WIDTH, MAP_HEIGHT);
        nt       = step_coord(16'(tx[sel]), 16'(ty[sel]), peek[sel], WRAP, MAP_WIDTH, MAP_HEIGHT);
        grow_dec = (grow_cnt[sel] != 2'd0);
        grow_ok  = grow_dec && (len[sel] < LW'(MAX_LEN));
        for (int i = 0; i < NUM_SNAKES; i++) begin
            push[i] = (state == S_CALC) && (sel == SW'(i)) && (d != DIR_NONE);
            pop[i]  = push[i] && !grow_ok;
        end
    end

    assign unused_coord_hi = ^{nh.x[15:XW], nh.y[15:YW], nt.x[15:XW], nt.y[15:YW]};
    assign busy = (state != S_IDLE) || (|pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sel         <= '0;
            rr_ptr      <= '0;
            pending     <= '0;
            missed_step <= '0;
            tile_we     <= 1'b0;
            tail_moved  <= 1'b0;
            for (int i = 0; i < NUM_SNAKES; i++) begin
                grow_cnt[i] <= 2'd0;
                hx[i]       <= XW'(START_X + i*START_SPACING);
                hy[i]       <= YW'(START_Y);
                tx[i]       <= XW'(START_X + i*START_SPACING);
                ty[i]       <= YW'(START_Y + START_LENGTH - 1);
                len[i]      <= LW'(START_LENGTH);
            end
        end else begin
            pending <= (pending & ~clr_mask) | step;
            for (int i = 0; i < NUM_SNAKES; i++) begin
                if (step[i] && pending[i] && !clr_mask[i]) missed_step[i] <= 1'b1;
                case ({grow[i], push[i] && grow_dec})
                    2'b10:   if (grow_cnt[i] != 2'd3) grow_cnt[i] <= grow_cnt[i] + 2'd1;
                    2'b01:   grow_cnt[i] <= grow_cnt[i] - 2'd1;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        sel   <= pick;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (d == DIR_NONE) begin
                        rr_ptr <= next_rr;
                        state  <= S_IDLE;
                    end else begin
                        hx[sel]   <= nh.x[XW-1:0];
                        hy[sel]   <= nh.y[YW-1:0];
                        old_tx    <= tx[sel];
                        old_ty    <= ty[sel];
                        if (grow_ok) begin
                            len[sel]   <= len[sel] + LW'(1);
                            tail_moved <= 1'b0;
                        end else begin
                            tx[sel]    <= nt.x[XW-1:0];
                            ty[sel]    <= nt.y[YW-1:0];
                            tail_moved <= 1'b1;
                        end
                        tile_we   <= 1'b1;
                        tile_x    <= nh.x[XW-1:0];
                        tile_y    <= nh.y[YW-1:0];
                        tile_data <= snake_tile(int'(sel));
                        state     <= S_WR_HEAD;
                    end
                end
                S_WR_HEAD: begin
                    // A head landing on the vacated tail tile already overwrote it.
                    if (tile_ready) begin
                        if (tail_moved && (tile_x != old_tx || tile_y != old_ty)) begin
                            tile_x    <= old_tx;
                            tile_y    <= old_ty;
                            tile_data <= TILE_EMPTY;
                            state     <= S_WR_TAIL;
                        end else begin
                            tile_we <= 1'b0;
                            rr_ptr  <= next_rr;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_WR_TAIL: begin
                    if (tile_ready) begin
                        tile_we <= 1'b0;
                        rr_ptr  <= next_rr;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SNAKES; g++) begin : g_snake
        snake_dir_ring #(
            .MAX_LEN      (MAX_LEN),
            .START_LENGTH (START_LENGTH)
        ) u_ring (
            .clk      (clk),
            .rst      (rst),
            .push     (push[g]),
            .push_dir (d),
            .pop      (pop[g]),
            .peek     (peek[g])
        );
        assign head_x[g*XW +: XW] = hx[g];
        assign head_y[g*YW +: YW] = hy[g];
        assign tail_x[g*XW +: XW] = tx[g];
        assign tail_y[g*YW +: YW] = ty[g];
        assign length[g*LW +: LW] = len[g];
    end

endmodule

// File: tb/tb_snake_multi_mover.sv
// Bench for snake_multi_mover: directed scenarios plus random steps/grows,
// checked against a coordinate-list model of each snake body.
module tb_snake_multi_mover;

    localparam int N    = 2;
    localparam int W    = 64;
    localparam int H    = 48;
    localparam int XW   = 6;
    localparam int YW   = 6;
    localparam int LW   = 7;
    localparam int MAXL = 64;
    localparam logic [1:0] MIR = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      step = '0;
    logic [N-1:0]      grow = '0;
    logic [N*3-1:0]    dir = '0;
    logic              tile_ready = 1'b1;
    logic              tile_we;
    logic [XW-1:0]     tile_x;
    logic [YW-1:0]     tile_y;
    snake_pkg::tile_t  tile_data;
    logic [N*XW-1:0]   head_x;
    logic [N*YW-1:0]   head_y;
    logic [N*XW-1:0]   tail_x;
    logic [N*YW-1:0]   tail_y;
    logic [N*LW-1:0]   length;
    logic              busy;
    logic [N-1:0]      missed_step;

    snake_multi_mover dut (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
        .tile_we(tile_we), .tile_x(tile_x), .tile_y(tile_y), .tile_data(tile_data),
        .tile_ready(tile_ready), .head_x(head_x), .head_y(head_y),
        .tail_x(tail_x), .tail_y(tail_y), .length(length), .busy(busy),
        .missed_step(missed_step)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each body is an ordered list of tiles, head first.
    int bx [N][MAXL];
    int by [N][MAXL];
    int blen [N];
    int gcnt [N];
    int ewx[$], ewy[$], ewd[$];
    int owx[$], owy[$], owd[$];

    always @(posedge clk) begin
        if (!rst && tile_we && tile_ready) begin
            owx.push_back(int'(tile_x));
            owy.push_back(int'(tile_y));
            owd.push_back(int'(tile_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int hx_of(input int i); return int'(head_x[i*XW +: XW]); endfunction
    function automatic int hy_of(input int i); return int'(head_y[i*YW +: YW]); endfunction
    function automatic int tx_of(input int i); return int'(tail_x[i*XW +: XW]); endfunction
    function automatic int ty_of(input int i); return int'(tail_y[i*YW +: YW]); endfunction
    function automatic int len_of(input int i); return int'(length[i*LW +: LW]); endfunction

    function automatic void clear_logs();
        ewx.delete(); ewy.delete(); ewd.delete();
        owx.delete(); owy.delete(); owd.delete();
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            blen[i] = 4;
            gcnt[i] = 0;
            for (int k = 0; k < 4; k++) begin
                bx[i][k] = 8 + 16*i;
                by[i][k] = 10 + k;
            end
        end
    endfunction

    // Directions: 0 none, 1 up, 2 down, 3 left, 4 right.
    function automatic void model_step(input int i, input int d_in);
        int d, nx, ny, otx, oty;
        bit g;
        d = d_in;
        if (MIR[i]) d = (d == 1) ? 2 : (d == 2) ? 1 : (d == 3) ? 4 : (d == 4) ? 3 : d;
        if (d == 0) return;
        nx  = (bx[i][0] + ((d == 4) ? 1 : 0) - ((d == 3) ? 1 : 0) + W) % W;
        ny  = (by[i][0] + ((d == 2) ? 1 : 0) - ((d == 1) ? 1 : 0) + H) % H;
        otx = bx[i][blen[i]-1];
        oty = by[i][blen[i]-1];
        g   = (gcnt[i] > 0) && (blen[i] < MAXL);
        if (gcnt[i] > 0) gcnt[i]--;
        for (int k = blen[i]; k > 0; k--) begin
            if (k < MAXL) begin
                bx[i][k] = bx[i][k-1];
                by[i][k] = by[i][k-1];
            end
        end
        bx[i][0] = nx;
        by[i][0] = ny;
        if (g) blen[i]++;
        ewx.push_back(nx); ewy.push_back(ny); ewd.push_back(i + 1);
        if (!g && !(nx == otx && ny == oty)) begin
            ewx.push_back(otx); ewy.push_back(oty); ewd.push_back(0);
        end
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        step = '0;
        grow = '0;
        tile_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        clear_logs();
    endtask

    task automatic run_until_idle(input bit rnd, output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            tile_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        tile_ready = 1'b1;
        chk("busy_timeout", int'(busy), 0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, owx.size(), ewx.size());
        for (int k = 0; k < ewx.size() && k < owx.size(); k++) begin
            chk($sformatf("%s_wr%0d_x", tag, k), owx[k], ewx[k]);
            chk($sformatf("%s_wr%0d_y", tag, k), owy[k], ewy[k]);
            chk($sformatf("%s_wr%0d_data", tag, k), owd[k], ewd[k]);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_head_x%0d", tag, i), hx_of(i), bx[i][0]);
            chk($sformatf("%s_head_y%0d", tag, i), hy_of(i), by[i][0]);
            chk($sformatf("%s_tail_x%0d", tag, i), tx_of(i), bx[i][blen[i]-1]);
            chk($sformatf("%s_tail_y%0d", tag, i), ty_of(i), by[i][blen[i]-1]);
            chk($sformatf("%s_len%0d", tag, i), len_of(i), blen[i]);
        end
    endtask

    task automatic do_step(input string tag, input int i, input int d, input bit rnd, output int cyc);
        clear_logs();
        model_step(i, d);
        dir[i*3 +: 3] = 3'(d);
        step[i] = 1'b1;
        tick();
        step = '0;
        run_until_idle(rnd, cyc);
        check_writes(tag);
        check_state(tag);
    endtask

    task automatic do_grow(input int i);
        if (gcnt[i] < 3) gcnt[i]++;
        grow[i] = 1'b1;
        tick();
        grow = '0;
    endtask

    initial begin
        int cyc;
        int sx, sy, sd, changes;

        do_reset();
        chk("rst_head_x0", hx_of(0), 8);
        chk("rst_head_y0", hy_of(0), 10);
        chk("rst_tail_x0", tx_of(0), 8);
        chk("rst_tail_y0", ty_of(0), 13);
        chk("rst_len0", len_of(0), 4);
        chk("rst_head_x1", hx_of(1), 24);
        chk("rst_head_y1", hy_of(1), 10);
        chk("rst_tile_we", int'(tile_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_missed", int'(missed_step), 0);

        // Plain move: head write then tail clear, busy for four cycles.
        do_step("up0", 0, 1, 1'b0, cyc);
        chk("up0_busy_cycles", cyc, 4);
        chk("up0_tail_y", ty_of(0), 12);
        if (owx.size() == 2) begin
            chk("up0_head_wr_y", owy[0], 9);
            chk("up0_tail_wr_y", owy[1], 13);
            chk("up0_tail_wr_data", owd[1], 0);
        end

        // Growth keeps the tail and issues only the head write.
        do_reset();
        do_grow(0);
        do_step("grow0", 0, 4, 1'b0, cyc);
        chk("grow0_head_x", hx_of(0), 9);
        chk("grow0_len", len_of(0), 5);
        chk("grow0_tail_y", ty_of(0), 13);
        chk("grow0_writes", owx.size(), 1);

        // Simultaneous steps: snake0 served first, snake1 mirrored UP -> DOWN.
        do_reset();
        clear_logs();
        model_step(0, 4);
        model_step(1, 1);
        dir = {3'd1, 3'd4};
        step = 2'b11;
        tick();
        step = '0;
        run_until_idle(1'b0, cyc);
        check_writes("both");
        check_state("both");
        chk("both_first_data", (owd.size() > 0) ? owd[0] : -1, 1);
        chk("both_head_y1", hy_of(1), 11);

        // Stalled write, overlapping steps on snake1, then reset mid-write.
        do_reset();
        tile_ready = 1'b0;
        dir = {3'd0, 3'd1};
        step = 2'b01;
        tick();
        step = '0;
        tick();
        tick();
        chk("stall_we", int'(tile_we), 1);
        sx = int'(tile_x);
        sy = int'(tile_y);
        sd = int'(tile_data);
        chk("stall_x", sx, 8);
        chk("stall_y", sy, 9);
        step = 2'b10;
        tick();
        tick();
        step = '0;
        changes = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (int'(tile_x) != sx || int'(tile_y) != sy || int'(tile_data) != sd || !tile_we)
                changes++;
        end
        chk("stall_stable", changes, 0);
        chk("stall_missed", int'(missed_step), 2);
        chk("stall_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk("midrst_we", int'(tile_we), 0);
        chk("midrst_missed", int'(missed_step), 0);
        chk("midrst_head_y0", hy_of(0), 10);
        do_reset();
        chk("midrst_busy", int'(busy), 0);

        // Left edge wrap.
        for (int k = 0; k < 9; k++) do_step($sformatf("left%0d", k), 0, 3, 1'b0, cyc);
        chk("wrap_head_x", hx_of(0), 63);

        // Tail chasing: head lands on the old tail, no EMPTY write.
        do_reset();
        do_step("chase_r", 0, 4, 1'b0, cyc);
        do_step("chase_d", 0, 2, 1'b0, cyc);
        do_step("chase_l", 0, 3, 1'b0, cyc);
        chk("chase_writes", owx.size(), 1);
        chk("chase_head_x", hx_of(0), 8);
        chk("chase_head_y", hy_of(0), 11);

        // Random steps and grows with a random ready pattern.
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int sn;
            sn = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0) do_grow(sn);
            else do_step($sformatf("rnd%0d", n), sn, $urandom_range(0, 4), 1'b1, cyc);
        end
        chk("rnd_missed", int'(missed_step), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
